// File: rtl/o_delay_pkg.sv
// Shared types and constants for the O_DELAY tap controller.
package o_delay_pkg;

    localparam int unsigned TAP_W          = 6;
    localparam int unsigned STEP_W         = 7;
    localparam int unsigned SETTLE_CYC_DEF = 4;
    localparam int unsigned MAX_STEPS_DEF  = 64;

    typedef logic [TAP_W-1:0]  tap_t;
    typedef logic [STEP_W-1:0] step_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        CMP    = 3'd3,
        STEP   = 3'd4
    } state_t;

    // Adjust direction: 1 = increment, when the target lies above the readback (unsigned).
    function automatic logic tap_dir_up(input tap_t target, input tap_t cur);
        return (target > cur);
    endfunction

endpackage

// File: rtl/o_delay_tap_ctrl.sv
// Sequences O_DELAY load/adjust pulses until the tap readback reaches a requested value.
// One adjust pulse at a time; after each pulse the readback is given SETTLE_CYC cycles
// before it is sampled and compared.
module o_delay_tap_ctrl
    import o_delay_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int unsigned MAX_STEPS  = MAX_STEPS_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_load_i,
    input  logic [TAP_W-1:0] req_tap_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [TAP_W-1:0] cur_tap_o,
    output logic             dly_ld_o,
    output logic             dly_adj_o,
    output logic             dly_incdec_o,
    input  logic [TAP_W-1:0] dly_tap_val_i
);

    // Counter reload value: SETTLE lasts SETTLE_CYC cycles, counting down to zero.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam step_t      STEP_LIMIT  = step_t'(MAX_STEPS);

    state_t      state_r;
    tap_t        target_r;
    tap_t        prev_tap_r;
    tap_t        cur_tap_r;
    step_t       step_cnt_r;
    logic [3:0]  settle_cnt_r;
    logic        adj_seen_r;
    logic        ready_r;
    logic        busy_r;
    logic        done_r;
    logic        err_r;
    logic        ld_r;
    logic        adj_r;
    logic        incdec_r;

    // Controller FSM: owns every register and drives all outputs from flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= IDLE;
            target_r     <= 6'd0;
            prev_tap_r   <= 6'd0;
            cur_tap_r    <= 6'd0;
            step_cnt_r   <= 7'd0;
            settle_cnt_r <= 4'd0;
            adj_seen_r   <= 1'b0;
            ready_r      <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            ld_r         <= 1'b0;
            adj_r        <= 1'b0;
            incdec_r     <= 1'b0;
        end else begin
            // Pulses default low; each state raises the one it owns.
            done_r <= 1'b0;
            err_r  <= 1'b0;
            ld_r   <= 1'b0;
            adj_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_valid_i && ready_r) begin
                        target_r   <= req_tap_i;
                        step_cnt_r <= 7'd0;
                        adj_seen_r <= 1'b0;
                        ready_r    <= 1'b0;
                        busy_r     <= 1'b1;
                        if (req_load_i) begin
                            state_r <= LOAD;
                            ld_r    <= 1'b1;
                        end else begin
                            state_r      <= SETTLE;
                            settle_cnt_r <= SETTLE_LAST;
                        end
                    end
                end
                LOAD: begin
                    state_r      <= SETTLE;
                    settle_cnt_r <= SETTLE_LAST;
                end
                SETTLE: begin
                    if (settle_cnt_r == 4'd0) begin
                        cur_tap_r <= dly_tap_val_i;
                        state_r   <= CMP;
                    end else begin
                        settle_cnt_r <= settle_cnt_r - 4'd1;
                    end
                end
                CMP: begin
                    if (cur_tap_r == target_r) begin
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end else if ((adj_seen_r && (cur_tap_r == prev_tap_r)) ||
                                 (step_cnt_r == STEP_LIMIT)) begin
                        // Tap did not move after an adjust, or the step budget is spent.
                        err_r   <= 1'b1;
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end else begin
                        state_r    <= STEP;
                        adj_r      <= 1'b1;
                        incdec_r   <= tap_dir_up(target_r, cur_tap_r);
                        prev_tap_r <= cur_tap_r;
                        step_cnt_r <= step_cnt_r + 7'd1;
                        adj_seen_r <= 1'b1;
                    end
                end
                STEP: begin
                    state_r      <= SETTLE;
                    settle_cnt_r <= SETTLE_LAST;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o  = ready_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign err_o        = err_r;
    assign cur_tap_o    = cur_tap_r;
    assign dly_ld_o     = ld_r;
    assign dly_adj_o    = adj_r;
    assign dly_incdec_o = incdec_r;

endmodule

// File: tb/tb_o_delay_tap_ctrl.sv
// Bench for o_delay_tap_ctrl: an O_DELAY readback model plus a per-request timeline
// model derived from the step/settle latency rules, compared every cycle.
`timescale 1ns/1ps
module tb_o_delay_tap_ctrl;

    localparam int S    = 4;
    localparam int MAXS = 40;

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       done;
        logic       err;
        logic       ld;
        logic       adj;
        logic       inc;
        logic [5:0] cur;
    } exp_t;

    typedef struct {
        string name;
        int    act;
        int    expv;
    } spot_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_load, busy, done, err;
    logic       dly_ld, dly_adj, dly_incdec;
    logic [5:0] req_tap, cur_tap, tap_val;

    int     vectors     = 0;
    int     miscompares = 0;
    exp_t   exp_q[$];
    spot_t  spot_q[$];
    bit     chk_en   = 1'b0;
    logic [5:0] last_cur = 6'd0;
    logic       last_inc = 1'b0;

    logic [5:0] prim_tap;
    logic [5:0] dflt    = 6'd20;
    logic [5:0] set_val = 6'd0;
    bit         set_req = 1'b0;
    bit         frozen  = 1'b0;
    int inc_cnt = 0, dec_cnt = 0, ld_cnt = 0, done_cnt = 0, err_cnt = 0;

    always #5 clk = ~clk;

    o_delay_tap_ctrl #(.SETTLE_CYC(S), .MAX_STEPS(MAXS)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_load_i(req_load), .req_tap_i(req_tap),
        .busy_o(busy), .done_o(done), .err_o(err), .cur_tap_o(cur_tap),
        .dly_ld_o(dly_ld), .dly_adj_o(dly_adj), .dly_incdec_o(dly_incdec),
        .dly_tap_val_i(tap_val)
    );

    // O_DELAY model: load to default, saturating +/-1 on adjust, optionally frozen.
    always @(posedge clk) begin
        if (set_req) prim_tap <= set_val;
        else if (!frozen) begin
            if (dly_ld) prim_tap <= dflt;
            else if (dly_adj) begin
                if (dly_incdec) prim_tap <= (prim_tap == 6'd63) ? 6'd63 : prim_tap + 6'd1;
                else            prim_tap <= (prim_tap == 6'd0)  ? 6'd0  : prim_tap - 6'd1;
            end
        end
    end
    assign tap_val = prim_tap;

    // Pulse counters observed on the DUT outputs.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dly_adj && dly_incdec)  inc_cnt  <= inc_cnt + 1;
            if (dly_adj && !dly_incdec) dec_cnt  <= dec_cnt + 1;
            if (dly_ld)                 ld_cnt   <= ld_cnt + 1;
            if (done)                   done_cnt <= done_cnt + 1;
            if (err)                    err_cnt  <= err_cnt + 1;
        end
    end

    function automatic exp_t mk(logic r, logic b, logic d, logic e, logic l, logic a,
                                logic i, logic [5:0] c);
        return {r, b, d, e, l, a, i, c};
    endfunction

    // Single compare process: spot checks, then the cycle-by-cycle timeline.
    always @(negedge clk) begin
        spot_t s;
        exp_t  e;
        exp_t  a;
        while (spot_q.size() > 0) begin
            s = spot_q.pop_front();
            vectors++;
            if (s.act != s.expv) begin
                miscompares++;
                $display("FAIL %s: got %0d, expected %0d", s.name, s.act, s.expv);
            end
        end
        if (chk_en) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, last_inc, last_cur);
            a = {req_ready, busy, done, err, dly_ld, dly_adj, dly_incdec, cur_tap};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL cycle@%0t rdy,busy,done,err,ld,adj,inc,cur got %b,%b,%b,%b,%b,%b,%b,%0d expected %b,%b,%b,%b,%b,%b,%b,%0d",
                         $time, a.ready, a.busy, a.done, a.err, a.ld, a.adj, a.inc, a.cur,
                         e.ready, e.busy, e.done, e.err, e.ld, e.adj, e.inc, e.cur);
            end
        end
    end

    task automatic spot(input string n, input int a, input int e);
        spot_t s;
        s.name = n; s.act = a; s.expv = e;
        spot_q.push_back(s);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_prim(input logic [5:0] v);
        set_val = v; set_req = 1'b1;
        @(posedge clk); #1;
        set_req = 1'b0;
    endtask

    // Issue one request and enqueue its expected timeline. Each step costs
    // STEP + SETTLE + CMP; returns with the clock just past the done/err edge.
    task automatic req(input logic [5:0] t, input logic ld, input bit noise, output int len);
        logic [5:0] v, prev, curv;
        logic       incv;
        int         k, n, s, L;
        req_valid = 1'b1; req_tap = t; req_load = ld;
        @(posedge clk); #1;
        if (noise) begin req_tap = ~t; req_load = ~ld; end
        else req_valid = 1'b0;
        L = ld ? 1 : 0;
        v = (ld && !frozen) ? dflt : prim_tap;
        curv = last_cur; incv = last_inc; prev = 6'd0; k = 0; n = 0;
        while (1'b1) begin
            s = L + S + k * (S + 2);
            while (n < s) begin
                exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, (ld && (n == 0)), 1'b0, incv, curv));
                n++;
            end
            curv = v;
            exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, incv, curv));
            n++;
            if (v == t) begin
                exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, incv, curv));
                break;
            end
            if ((k > 0 && v == prev) || k == MAXS) begin
                exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, incv, curv));
                break;
            end
            incv = (t > v);
            exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, incv, curv));
            n++;
            prev = v;
            if (!frozen) v = incv ? v + 6'd1 : v - 6'd1;
            k++;
        end
        len = n;
        last_cur = curv;
        last_inc = incv;
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            if (i == 2) req_valid = 1'b0;
        end
    endtask

    initial begin
        int len, i0, d0, l0, dn0, e0;
        bit seen;
        logic [5:0] t;
        logic       ld;
        rst_n = 1'b0; req_valid = 1'b0; req_tap = 6'd0; req_load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        spot("rst_ready", req_ready, 1);
        spot("rst_busy", busy, 0);
        spot("rst_done_err", {done, err}, 0);
        spot("rst_ld_adj", {dly_ld, dly_adj, dly_incdec}, 0);
        spot("rst_cur_tap", cur_tap, 0);
        set_prim(6'd0);
        rst_n = 1'b1; chk_en = 1'b1;
        idle(2);

        // 0 -> 5: five increments, done 35 edges after acceptance.
        i0 = inc_cnt; d0 = dec_cnt;
        req(6'd5, 1'b0, 1'b0, len);
        spot("lat_tap5", len, 35);
        idle(1);
        spot("inc_tap5", inc_cnt - i0, 5);
        spot("dec_tap5", dec_cnt - d0, 0);
        spot("cur_tap5", cur_tap, 5);

        // 40 -> 37: three decrements; 40 -> 40: no pulses.
        set_prim(6'd40);
        i0 = inc_cnt; d0 = dec_cnt;
        req(6'd37, 1'b0, 1'b0, len);
        idle(1);
        spot("dec_tap37", dec_cnt - d0, 3);
        spot("inc_tap37", inc_cnt - i0, 0);
        set_prim(6'd40);
        i0 = inc_cnt; d0 = dec_cnt;
        req(6'd40, 1'b0, 1'b0, len);
        spot("lat_equal", len, 5);
        idle(1);
        spot("adj_equal", (inc_cnt - i0) + (dec_cnt - d0), 0);

        // Load to default 20, then seek 22.
        dflt = 6'd20; set_prim(6'd7);
        i0 = inc_cnt; l0 = ld_cnt;
        req(6'd22, 1'b1, 1'b0, len);
        idle(1);
        spot("ld_pulses", ld_cnt - l0, 1);
        spot("inc_load22", inc_cnt - i0, 2);
        spot("cur_load22", cur_tap, 22);

        // Stuck readback at 10, target 12: one pulse then err; next request normal.
        frozen = 1'b1; set_prim(6'd10);
        i0 = inc_cnt; dn0 = done_cnt; e0 = err_cnt;
        req(6'd12, 1'b0, 1'b0, len);
        idle(1);
        spot("stuck_err", err_cnt - e0, 1);
        spot("stuck_done", done_cnt - dn0, 0);
        spot("stuck_adj", inc_cnt - i0, 1);
        frozen = 1'b0;
        dn0 = done_cnt;
        req(6'd13, 1'b0, 1'b0, len);
        idle(1);
        spot("after_stuck_done", done_cnt - dn0, 1);

        // Back-to-back with busy-time noise on the request inputs.
        req(6'd30, 1'b0, 1'b1, len);
        req(6'd2, 1'b0, 1'b1, len);
        idle(1);
        spot("b2b_cur", cur_tap, 2);

        // Step limit: 0 -> 63 aborts at MAXS steps; 0 -> MAXS still completes.
        set_prim(6'd0);
        e0 = err_cnt;
        req(6'd63, 1'b0, 1'b0, len);
        idle(1);
        spot("limit_err", err_cnt - e0, 1);
        spot("limit_cur", cur_tap, MAXS);
        set_prim(6'd0);
        dn0 = done_cnt;
        req(6'(MAXS), 1'b0, 1'b0, len);
        idle(1);
        spot("limit_exact_done", done_cnt - dn0, 1);

        // Reset while an adjust pulse is high.
        set_prim(6'd0);
        chk_en = 1'b0;
        req_valid = 1'b1; req_tap = 6'd5; req_load = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (dly_adj) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        spot("adj_before_rst", seen, 1);
        #2 rst_n = 1'b0;
        #1 spot("rst_cuts_adj", dly_adj, 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        spot("post_rst_ready", req_ready, 1);
        spot("post_rst_busy", busy, 0);
        spot("post_rst_cur", cur_tap, 0);
        last_cur = 6'd0; last_inc = 1'b0; chk_en = 1'b1;
        idle(1);

        // Randomized requests against the timeline model.
        for (int r = 0; r < 25; r++) begin
            frozen = ($urandom_range(5) == 0);
            if ($urandom_range(1) == 1 || frozen) set_prim(6'($urandom_range(63)));
            dflt = 6'($urandom_range(63));
            t    = 6'($urandom_range(63));
            ld   = frozen ? 1'b0 : 1'($urandom_range(1));
            req(t, ld, 1'($urandom_range(1)), len);
            if ($urandom_range(2) != 0) idle($urandom_range(3, 1));
        end
        frozen = 1'b0;
        idle(2);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
